// File: rtl/inst_mem_loader_pkg.sv
// Shared widths and FSM encoding for the instruction-memory loader.
package defines;

    localparam int unsigned N             = 32;
    localparam int unsigned INST_MEM_SIZE = 64;
    localparam int unsigned MEM_CELL_SIZE = 8;

    localparam int unsigned ADDR_W = $clog2(INST_MEM_SIZE);
    localparam int unsigned CNT_W  = $clog2(INST_MEM_SIZE / 4) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: accepts 32-bit words over valid/ready and writes
// each as four byte cells, most-significant byte at the lowest address.
// Optional feature macro: LOADER_CHECKSUM_EN (adds XOR checksum output).
module inst_mem_loader
    import defines::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [N-1:0]             base_addr,
    input  logic                     word_valid,
    input  logic [N-1:0]             word_data,
    input  logic                     word_last,
    output logic                     word_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [MEM_CELL_SIZE-1:0] mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [CNT_W-1:0]         word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [N-1:0]             checksum
`endif
);

    // Address register is one bit wider so a session that fills the last
    // cell can advance past the end without wrapping to 0.
    localparam logic [ADDR_W+1:0] LAST_CELL = (ADDR_W+2)'(INST_MEM_SIZE - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   cur_addr_q, cur_addr_d;
    logic [N-1:0]      word_q, word_d;
    logic              last_q, last_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [N-1:0]      csum_q, csum_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            word_q     <= word_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            err_q      <= err_d;
            csum_q     <= csum_d;
        end
    end

    // Next-state logic: session start checks, word capture, byte sequencing
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        word_d     = word_q;
        last_d     = last_q;
        idx_d      = idx_q;
        count_d    = count_q;
        err_d      = 1'b0;
        csum_d     = csum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((base_addr[1:0] != 2'b00) || (base_addr >= N'(INST_MEM_SIZE))) begin
                        err_d = 1'b1;
                    end else begin
                        cur_addr_d = base_addr[ADDR_W:0];
                        count_d    = '0;
                        csum_d     = '0;
                        state_d    = WAIT_WORD;
                    end
                end
            end
            WAIT_WORD: begin
                if (word_valid) begin
                    word_d = word_data;
                    last_d = word_last;
                    if (({1'b0, cur_addr_q} + (ADDR_W+2)'(3)) > LAST_CELL) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cur_addr_d = cur_addr_q + (ADDR_W+1)'(4);
                    count_d    = count_q + CNT_W'(1);
                    csum_d     = csum_q ^ word_q;
                    state_d    = last_q ? DONE : WAIT_WORD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        word_ready = (state_q == WAIT_WORD);
        busy       = (state_q == WAIT_WORD) || (state_q == WRITE);
        done       = (state_q == DONE);
        err        = err_q;
        word_count = count_q;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state_q == WRITE) begin
            mem_we   = 1'b1;
            mem_addr = cur_addr_q[ADDR_W-1:0] + ADDR_W'(idx_q);
            case (idx_q)
                2'd0:    mem_wdata = word_q[N-1    -: MEM_CELL_SIZE];
                2'd1:    mem_wdata = word_q[N-1-8  -: MEM_CELL_SIZE];
                2'd2:    mem_wdata = word_q[N-1-16 -: MEM_CELL_SIZE];
                default: mem_wdata = word_q[N-1-24 -: MEM_CELL_SIZE];
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: byte writes go through a
// scoreboard queue; control outputs are checked inline per scenario.
module tb_inst_mem_loader;
    import defines::*;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     start;
    logic [N-1:0]             base_addr;
    logic                     word_valid;
    logic [N-1:0]             word_data;
    logic                     word_last;
    logic                     word_ready;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [MEM_CELL_SIZE-1:0] mem_wdata;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [CNT_W-1:0]         word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [N-1:0]             checksum;
`endif

    int errors = 0;
    int checks = 0;
    logic [ADDR_W+MEM_CELL_SIZE-1:0] exp_q[$];

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .base_addr  (base_addr),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // Scoreboard: every byte write must match the oldest expected byte
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", mem_addr, mem_wdata);
            end else begin
                logic [ADDR_W+MEM_CELL_SIZE-1:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL byte_write addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e[ADDR_W+MEM_CELL_SIZE-1:MEM_CELL_SIZE], e[MEM_CELL_SIZE-1:0]);
                end
            end
        end
    end

    task automatic start_session(input logic [N-1:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for word_ready, offers one word, optionally queues its bytes
    task automatic send_word(input logic [N-1:0] d, input logic l,
                             input int unsigned addr, input bit push);
        int n = 0;
        while (word_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (word_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout word_ready=%b expected 1 within 50 cycles", word_ready);
        end
        word_valid = 1'b1;
        word_data  = d;
        word_last  = l;
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                logic [N-1:0] sh;
                sh = d >> (8 * (3 - k));
                exp_q.push_back({ADDR_W'(addr + k), sh[7:0]});
            end
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 0; base_addr = '0; word_valid = 0; word_data = '0; word_last = 0;
        #3;
        checks += 8;
        if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_word_ready got=%b exp=0", word_ready); end
        if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        if (mem_addr !== '0)     begin errors++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
        if (mem_wdata !== '0)    begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        if (word_count !== '0)   begin errors++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_word;
        start_session(32'd0);
        checks += 2;
        if (word_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after_start got=%b exp=1", word_ready); end
        if (busy !== 1'b1)       begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        send_word(32'h8001000A, 1'b1, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem_we !== 1'b1 || word_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_burst cycle=%0d mem_we=%b word_ready=%b exp 1/0", k, mem_we, word_ready);
            end
            @(posedge clk); #1;
        end
        checks += 3;
        if (done !== 1'b1)         begin errors++; $display("FAIL single_done got=%b exp=1", done); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL single_busy_at_done got=%b exp=0", busy); end
        if (word_count !== 5'd1)   begin errors++; $display("FAIL single_count got=%0d exp=1", word_count); end
        @(posedge clk); #1;
        checks += 2;
        if (done !== 1'b0)         begin errors++; $display("FAIL single_done_pulse got=%b exp=0", done); end
        if (exp_q.size() != 0)     begin errors++; $display("FAIL single_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_two_words;
        start_session(32'd4);
        send_word(32'h04011800, 1'b0, 4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (word_ready !== 1'b0) begin errors++; $display("FAIL two_burst1_ready cycle=%0d got=%b exp=0", k, word_ready); end
            @(posedge clk); #1;
        end
        checks += 2;
        if (word_ready !== 1'b1) begin errors++; $display("FAIL two_ready_again got=%b exp=1", word_ready); end
        if (word_count !== 5'd1) begin errors++; $display("FAIL two_count_mid got=%0d exp=1", word_count); end
        send_word(32'h0C600800, 1'b1, 8, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (word_ready !== 1'b0) begin errors++; $display("FAIL two_burst2_ready cycle=%0d got=%b exp=0", k, word_ready); end
            @(posedge clk); #1;
        end
        checks += 3;
        if (done !== 1'b1)       begin errors++; $display("FAIL two_done got=%b exp=1", done); end
        if (word_count !== 5'd2) begin errors++; $display("FAIL two_count got=%0d exp=2", word_count); end
        if (exp_q.size() != 0)   begin errors++; $display("FAIL two_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_bad_start;
        logic [N-1:0] bases [2];
        bases[0] = 32'd2;
        bases[1] = 32'd64;
        for (int i = 0; i < 2; i++) begin
            start_session(bases[i]);
            checks += 3;
            if (err !== 1'b1)        begin errors++; $display("FAIL bad_start_err base=%0d got=%b exp=1", bases[i], err); end
            if (busy !== 1'b0)       begin errors++; $display("FAIL bad_start_busy base=%0d got=%b exp=0", bases[i], busy); end
            if (word_ready !== 1'b0) begin errors++; $display("FAIL bad_start_ready base=%0d got=%b exp=0", bases[i], word_ready); end
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b0)        begin errors++; $display("FAIL bad_start_err_pulse base=%0d got=%b exp=0", bases[i], err); end
        end
    endtask

    task automatic test_overflow;
        start_session(32'd56);
        send_word(32'hA1A2A3A4, 1'b0, 56, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        send_word(32'hB1B2B3B4, 1'b0, 60, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        send_word(32'hC1C2C3C4, 1'b1, 64, 1'b0);
        checks += 4;
        if (err !== 1'b1)        begin errors++; $display("FAIL ovf_err got=%b exp=1", err); end
        if (mem_we !== 1'b0)     begin errors++; $display("FAIL ovf_mem_we got=%b exp=0", mem_we); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL ovf_busy got=%b exp=0", busy); end
        if (word_count !== 5'd2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", word_count); end
        @(posedge clk); #1;
        checks += 2;
        if (err !== 1'b0)        begin errors++; $display("FAIL ovf_err_pulse got=%b exp=0", err); end
        if (exp_q.size() != 0)   begin errors++; $display("FAIL ovf_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        start_session(32'd0);
        send_word(32'h11223344, 1'b1, 0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        checks += 6;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL rst_mid_mem we=%b addr=%0d data=%h exp all 0", mem_we, mem_addr, mem_wdata);
        end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        if (word_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got=%b exp=0", word_ready); end
        if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses done=%b err=%b exp 0/0", done, err); end
        if (word_count !== '0)   begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", word_count); end
        if (exp_q.size() != 2)   begin errors++; $display("FAIL rst_mid_bytes_left got=%0d exp=2", exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        start_session(32'd8);
        send_word(32'hDEADBEEF, 1'b1, 8, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        checks += 3;
        if (done !== 1'b1)       begin errors++; $display("FAIL rst_mid_recover_done got=%b exp=1", done); end
        if (word_count !== 5'd1) begin errors++; $display("FAIL rst_mid_recover_count got=%0d exp=1", word_count); end
        if (exp_q.size() != 0)   begin errors++; $display("FAIL rst_mid_recover_pending got=%0d exp=0", exp_q.size()); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        start_session(32'd0);
        send_word(32'h8001000A, 1'b0, 0, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        send_word(32'h04011800, 1'b1, 4, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (checksum !== 32'h8400180A) begin errors++; $display("FAIL checksum got=%h exp=8400180a", checksum); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_bad_start();
        test_overflow();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Sequential writer that fills the instruction memory from a 32-bit word stream before or between program runs. It accepts one instruction word per valid/ready handshake and writes it into the byte-cell instruction array as four consecutive byte writes. The most-significant byte goes to the lowest address, which is exactly the order the fetch side reassembles. It sits between the test/boot host interface and the write port of the instruction memory.

## Interface
Parameters (all taken from package `defines`, not overridden locally):
- N, 32, instruction/data word width
- INST_MEM_SIZE, 64, number of byte cells in instruction memory
- MEM_CELL_SIZE, 8, width of one memory cell

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  begin a load session at base_addr; sampled only in IDLE
- base_addr  input  N  byte address of first word; low 2 bits must be 0
- word_valid  input  1  word_data/word_last valid
- word_data  input  N  instruction word
- word_last  input  1  marks final word of session
- word_ready  output  1  loader can accept a word this cycle
- mem_we  output  1  byte write strobe to instruction memory
- mem_addr  output  $clog2(INST_MEM_SIZE)  byte cell address
- mem_wdata  output  MEM_CELL_SIZE  byte to write
- busy  output  1  session in progress
- done  output  1  one-cycle pulse, session completed normally
- err  output  1  one-cycle pulse, session aborted
- word_count  output  $clog2(INST_MEM_SIZE/4)+1  words written in current/last session

## Operation
- FSM states: IDLE, WAIT_WORD, WRITE, DONE.
- IDLE: word_ready=0, busy=0. On start:
  - if base_addr[1:0]!=0 or base_addr>=INST_MEM_SIZE: pulse err, stay IDLE;
  - else latch cur_addr=base_addr, clear word_count, go to WAIT_WORD.
- WAIT_WORD: word_ready=1, busy=1. On word_valid&&word_ready, latch word_data and word_last.
  - If cur_addr+3 > INST_MEM_SIZE-1 (computed one bit wider, no wrap): pulse err, go to IDLE. Nothing is written, and word_count is unchanged.
  - Otherwise go to WRITE with byte index 0.
- WRITE: word_ready=0, mem_we=1. For index k=0..3: mem_addr=cur_addr+k, mem_wdata=word[N-1-8k -: 8], so the MSB is written first.
  - After k=3: cur_addr+=4, word_count+=1. Go to DONE if the latched last is set, else back to WAIT_WORD.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start outside IDLE is ignored. word_valid outside WAIT_WORD is not consumed.
- Last word ending exactly at INST_MEM_SIZE-1 is legal and completes normally.
- Reset mid-session: immediately IDLE, all outputs 0. Bytes already written are not rolled back.

## Timing
- Reset values: word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, word_count=0.
- All outputs are registered or decoded from registered state. There is no combinational path from the inputs to the outputs.
- start accepted at edge T → word_ready=1 from T+1.
- Handshake at edge T → mem_we asserted in cycles T+1..T+4, one byte per cycle at consecutive addresses.
- After the fourth byte of a non-last word, word_ready=1 again in cycle T+5. Throughput is 1 word per 5 cycles.
- After the fourth byte of the last word, done=1 in cycle T+5 and busy=0.
- An err pulse occurs in the cycle after the offending start or handshake edge.

## Configuration
- LOADER_CHECKSUM_EN
  - Defined: adds output checksum (N bits), the XOR of all words written in the session. It is cleared on an accepted start, updated when each word's fourth byte is written, held after done, and 0 on reset.
  - Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `defines`: N, INST_MEM_SIZE, MEM_CELL_SIZE, and the enum typedef loader_state_t {IDLE, WAIT_WORD, WRITE, DONE}.
- The byte-lane selection (word, index → byte) is small enough to stay inline. There is no sub-module, because the block is a single FSM with an address counter.

## Test plan
- Reset, then start with base_addr=0 and word 0x8001000A with last=1 → writes 0x80@0, 0x01@1, 0x00@2, 0x0A@3 on four consecutive cycles; done pulse; word_count=1.
- Two-word session from base 4: 0x04011800, then 0x0C600800 with last=1 → bytes land at 4..11 in MSB-first order; word_ready low during each burst; word_count=2.
- start with base_addr=2 → err pulse next cycle; no mem_we; busy stays 0.
- base 56, three words, INST_MEM_SIZE=64 → words 1–2 fill 56..63; third handshake gives err with no write; word_count=2.
- Reset asserted during the second byte of a word → all outputs 0 asynchronously; later start works normally.
- With LOADER_CHECKSUM_EN: words 0x8001000A and 0x04011800 → checksum=0x8400180A after done.
